io_port_interface: RTL and testbench

Bus-slave I/O interface that answers the 8-bit `ior_`/`iow_` bus master (two address bits, bidirectional data). It sits between that master and two external devices. It holds one input byte, captured from an upstream producer over a dav_/rfd handshake, for the master to read. It also holds one output byte, written by the master, and hands it to a downstream consumer over the same kind of handshake.

---
 rtl/io_port_interface.sv | 154 +++++++++++++++
 tb/tb_io_port_interface.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_interface.sv
// Bus-slave I/O port: one input byte (RBR) from a dav_/rfd producer and one
// output byte (TBR) to a dav_/rfd consumer, accessed over an ior_/iow_ bus.
module io_port_interface (
    input  logic       clock,
    input  logic       reset_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic [1:0] a1_a0,
    inout  wire  [7:0] d7_d0,
    input  logic [7:0] in_data,
    input  logic       in_dav_,
    output logic       in_rfd,
    output logic [7:0] out_data,
    output logic       out_dav_,
    input  logic       out_rfd
);

    typedef enum logic [1:0] {I_READY, I_ACK, I_HOLD} in_st_e;
    typedef enum logic [1:0] {O_IDLE, O_VALID, O_RELEASE} out_st_e;

    in_st_e     in_st_q, in_st_d;
    out_st_e    out_st_q, out_st_d;
    logic       ior_q, ior_d;
    logic       iow_q, iow_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] rbr_q, rbr_d;
    logic [7:0] tbr_q, tbr_d;
    logic       fi_q, fi_d;
    logic       fo_q, fo_d;
    logic       ovr_q, ovr_d;
    logic       unr_q, unr_d;
    logic       in_rfd_q, in_rfd_d;
    logic       out_dav_q, out_dav_d;

    logic [7:0] str;
    logic [7:0] rd_data;
    logic       rd_done;
    logic       wr_go;

    assign str     = {4'b0000, unr_q, ovr_q, fo_q, fi_q};
    assign rd_done = ior_ && !ior_q;
    assign wr_go   = !iow_ && iow_q;

    always_comb begin
        case (a1_a0)
            2'd0:    rd_data = rbr_q;
            2'd2:    rd_data = str;
            default: rd_data = 8'h00;
        endcase
    end

    assign d7_d0    = ior_ ? 8'hzz : rd_data;
    assign in_rfd   = in_rfd_q;
    assign out_dav_ = out_dav_q;
    assign out_data = tbr_q;

    always_comb begin
        ior_d     = ior_;
        iow_d     = iow_;
        addr_d    = ior_ ? addr_q : a1_a0;
        rbr_d     = rbr_q;
        tbr_d     = tbr_q;
        fi_d      = fi_q;
        fo_d      = fo_q;
        ovr_d     = ovr_q;
        unr_d     = unr_q;
        in_rfd_d  = in_rfd_q;
        out_dav_d = out_dav_q;
        in_st_d   = in_st_q;
        out_st_d  = out_st_q;

        // Clears first so that a same-edge set of OVR/UNR wins.
        if (rd_done) begin
            if (addr_q == 2'd0) begin
                if (fi_q) fi_d = 1'b0;
                else      unr_d = 1'b1;
            end else if (addr_q == 2'd2) begin
                ovr_d = 1'b0;
                unr_d = 1'b0;
            end
        end

        if (wr_go && a1_a0 == 2'd1) begin
            if (fo_q) begin
                ovr_d = 1'b1;
            end else begin
                tbr_d = d7_d0;
                fo_d  = 1'b1;
            end
        end

        case (in_st_q)
            I_READY: if (!in_dav_) begin
                rbr_d    = in_data;
                fi_d     = 1'b1;
                in_rfd_d = 1'b0;
                in_st_d  = I_ACK;
            end
            I_ACK:   if (in_dav_) in_st_d = I_HOLD;
            I_HOLD:  if (!fi_q) begin
                in_rfd_d = 1'b1;
                in_st_d  = I_READY;
            end
            default: in_st_d = I_READY;
        endcase

        case (out_st_q)
            O_IDLE:    if (fo_q && out_rfd) begin
                out_dav_d = 1'b0;
                out_st_d  = O_VALID;
            end
            O_VALID:   if (!out_rfd) begin
                out_dav_d = 1'b1;
                fo_d      = 1'b0;
                out_st_d  = O_RELEASE;
            end
            O_RELEASE: if (out_rfd) out_st_d = O_IDLE;
            default:   out_st_d = O_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            addr_q    <= 2'd0;
            rbr_q     <= 8'h00;
            tbr_q     <= 8'h00;
            fi_q      <= 1'b0;
            fo_q      <= 1'b0;
            ovr_q     <= 1'b0;
            unr_q     <= 1'b0;
            in_rfd_q  <= 1'b1;
            out_dav_q <= 1'b1;
            in_st_q   <= I_READY;
            out_st_q  <= O_IDLE;
        end else begin
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            addr_q    <= addr_d;
            rbr_q     <= rbr_d;
            tbr_q     <= tbr_d;
            fi_q      <= fi_d;
            fo_q      <= fo_d;
            ovr_q     <= ovr_d;
            unr_q     <= unr_d;
            in_rfd_q  <= in_rfd_d;
            out_dav_q <= out_dav_d;
            in_st_q   <= in_st_d;
            out_st_q  <= out_st_d;
        end
    end

endmodule

// File: tb/tb_io_port_interface.sv
// Directed bench for io_port_interface: bus register table plus
// hand-written handshake and same-edge corner sequences.
module tb_io_port_interface;

    logic       clock = 1'b0;
    logic       reset_;
    logic       ior_;
    logic       iow_;
    logic [1:0] a1_a0;
    wire  [7:0] d7_d0;
    logic [7:0] in_data;
    logic       in_dav_;
    logic       in_rfd;
    logic [7:0] out_data;
    logic       out_dav_;
    logic       out_rfd;

    logic       drv_en;
    logic [7:0] drv_val;

    int total  = 0;
    int passed = 0;

    assign d7_d0 = drv_en ? drv_val : 8'hzz;

    always #5 clock = ~clock;

    io_port_interface dut (
        .clock   (clock),
        .reset_  (reset_),
        .ior_    (ior_),
        .iow_    (iow_),
        .a1_a0   (a1_a0),
        .d7_d0   (d7_d0),
        .in_data (in_data),
        .in_dav_ (in_dav_),
        .in_rfd  (in_rfd),
        .out_data(out_data),
        .out_dav_(out_dav_),
        .out_rfd (out_rfd)
    );

    typedef struct {
        bit         wr;
        logic [1:0] addr;
        logic [7:0] wdat;
        logic [7:0] exp_rd;
        logic [7:0] exp_tbr;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        a1_a0 = a;
        ior_  = 1'b0;
        #2;
        d = d7_d0;
        tick();
        ior_ = 1'b1;
        tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
        a1_a0   = a;
        drv_val = v;
        drv_en  = 1'b1;
        iow_    = 1'b0;
        tick();
        iow_   = 1'b1;
        drv_en = 1'b0;
        tick();
    endtask

    task automatic wait_for(input bit is_dav, input logic val,
                            input string nm);
        int n = 0;
        while (((is_dav ? out_dav_ : in_rfd) !== val) && n < 20) begin
            tick();
            n++;
        end
        chk(nm, {7'b0, (is_dav ? out_dav_ : in_rfd)}, {7'b0, val});
    endtask

    initial begin
        vec_t       tbl[10];
        logic [7:0] rd;

        tbl[0] = '{1'b1, 2'd1, 8'h3C, 8'h00, 8'h3C};
        tbl[1] = '{1'b1, 2'd1, 8'h77, 8'h00, 8'h3C};
        tbl[2] = '{1'b0, 2'd2, 8'h00, 8'h06, 8'h3C};
        tbl[3] = '{1'b0, 2'd2, 8'h00, 8'h02, 8'h3C};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 8'hA5, 8'h3C};
        tbl[5] = '{1'b0, 2'd2, 8'h00, 8'h0A, 8'h3C};
        tbl[6] = '{1'b1, 2'd3, 8'h99, 8'h00, 8'h3C};
        tbl[7] = '{1'b0, 2'd1, 8'h00, 8'h00, 8'h3C};
        tbl[8] = '{1'b0, 2'd3, 8'h00, 8'h00, 8'h3C};
        tbl[9] = '{1'b0, 2'd2, 8'h00, 8'h02, 8'h3C};

        reset_  = 1'b0;
        ior_    = 1'b1;
        iow_    = 1'b1;
        a1_a0   = 2'd0;
        in_data = 8'h5A;
        in_dav_ = 1'b0;
        out_rfd = 1'b0;
        drv_en  = 1'b0;
        drv_val = 8'h00;

        // Reset with a pending producer byte and a stalled consumer
        tick();
        tick();
        chk("rst_in_rfd", {7'b0, in_rfd}, 8'h01);
        chk("rst_out_dav", {7'b0, out_dav_}, 8'h01);
        chk("rst_out_data", out_data, 8'h00);
        drv_val = 8'h5C;
        drv_en  = 1'b1;
        #1;
        chk("rst_bus_release", d7_d0, 8'h5C);
        drv_en = 1'b0;
        a1_a0  = 2'd2;
        ior_   = 1'b0;
        #1;
        chk("rst_str", d7_d0, 8'h00);
        ior_ = 1'b1;
        tick();
        reset_ = 1'b1;
        tick();
        chk("cap_after_rst", {7'b0, in_rfd}, 8'h00);
        in_dav_ = 1'b1;
        a1_a0   = 2'd0;
        drv_val = 8'hA5;
        drv_en  = 1'b1;
        #1;
        chk("bus_hiz", d7_d0, 8'hA5);
        drv_en = 1'b0;
        tick();
        bus_read(2'd0, rd);
        chk("rst_rbr", rd, 8'h5A);
        tick();
        chk("rfd_back", {7'b0, in_rfd}, 8'h01);

        // Producer byte A5, status then data read
        in_data = 8'hA5;
        in_dav_ = 1'b0;
        tick();
        chk("a5_rfd_low", {7'b0, in_rfd}, 8'h00);
        in_dav_ = 1'b1;
        tick();
        bus_read(2'd2, rd);
        chk("a5_str", rd, 8'h01);
        bus_read(2'd0, rd);
        chk("a5_rbr", rd, 8'hA5);
        bus_read(2'd2, rd);
        chk("a5_str_clr", rd, 8'h00);
        chk("a5_rfd_up", {7'b0, in_rfd}, 8'h01);

        // Write 3C with consumer ready: dav_ one clock after the write edge
        out_rfd = 1'b1;
        a1_a0   = 2'd1;
        drv_val = 8'h3C;
        drv_en  = 1'b1;
        iow_    = 1'b0;
        tick();
        chk("wr_tbr", out_data, 8'h3C);
        chk("wr_dav_hi", {7'b0, out_dav_}, 8'h01);
        iow_   = 1'b1;
        drv_en = 1'b0;
        tick();
        chk("wr_dav_lo", {7'b0, out_dav_}, 8'h00);
        out_rfd = 1'b0;
        tick();
        chk("ack_dav_hi", {7'b0, out_dav_}, 8'h01);
        bus_read(2'd2, rd);
        chk("ack_str", rd, 8'h00);

        // Register table with consumer stalled
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].wdat);
            end else begin
                bus_read(tbl[i].addr, rd);
                chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            end
            chk($sformatf("tbl%0d_tbr", i), out_data, tbl[i].exp_tbr);
            chk($sformatf("tbl%0d_dav", i), {7'b0, out_dav_}, 8'h01);
        end

        // Write on the same edge that FO clears: dropped
        out_rfd = 1'b1;
        wait_for(1'b1, 1'b0, "drain1_dav_lo");
        out_rfd = 1'b0;
        a1_a0   = 2'd1;
        drv_val = 8'hEE;
        drv_en  = 1'b1;
        iow_    = 1'b0;
        tick();
        iow_   = 1'b1;
        drv_en = 1'b0;
        tick();
        chk("race_dav", {7'b0, out_dav_}, 8'h01);
        chk("race_tbr", out_data, 8'h3C);
        bus_read(2'd2, rd);
        chk("race_str", rd, 8'h04);
        bus_read(2'd2, rd);
        chk("race_str_clr", rd, 8'h00);

        // Status-read clear on the same edge as an OVR set: set wins
        bus_write(2'd1, 8'h11);
        a1_a0 = 2'd2;
        ior_  = 1'b0;
        tick();
        ior_    = 1'b1;
        a1_a0   = 2'd1;
        drv_val = 8'h22;
        drv_en  = 1'b1;
        iow_    = 1'b0;
        tick();
        iow_   = 1'b1;
        drv_en = 1'b0;
        tick();
        bus_read(2'd2, rd);
        chk("setwin_str", rd, 8'h06);
        bus_read(2'd2, rd);
        chk("setwin_str2", rd, 8'h02);
        out_rfd = 1'b1;
        wait_for(1'b1, 1'b0, "drain2_dav_lo");
        chk("drain2_data", out_data, 8'h11);
        out_rfd = 1'b0;
        wait_for(1'b1, 1'b1, "drain2_dav_hi");

        // Reader loop: producer -> master -> consumer
        for (int k = 1; k <= 3; k++) begin
            wait_for(1'b0, 1'b1, $sformatf("loop%0d_rfd", k));
            in_data = 8'(k);
            in_dav_ = 1'b0;
            tick();
            in_dav_ = 1'b1;
            bus_read(2'd2, rd);
            chk($sformatf("loop%0d_fi", k), rd, 8'h01);
            bus_read(2'd0, rd);
            chk($sformatf("loop%0d_rbr", k), rd, 8'(k));
            bus_write(2'd1, rd);
            out_rfd = 1'b1;
            wait_for(1'b1, 1'b0, $sformatf("loop%0d_dav", k));
            chk($sformatf("loop%0d_out", k), out_data, 8'(k));
            out_rfd = 1'b0;
            wait_for(1'b1, 1'b1, $sformatf("loop%0d_rel", k));
            bus_read(2'd2, rd);
            chk($sformatf("loop%0d_str", k), rd, 8'h00);
        end

        // Read RBR while empty
        bus_read(2'd0, rd);
        chk("unr_stale", rd, 8'h03);
        bus_read(2'd2, rd);
        chk("unr_str", rd, 8'h08);
        bus_read(2'd2, rd);
        chk("unr_str_clr", rd, 8'h00);

        // Asynchronous reset in the middle of an output handshake
        bus_write(2'd1, 8'h55);
        out_rfd = 1'b1;
        wait_for(1'b1, 1'b0, "abort_dav_lo");
        #2;
        reset_ = 1'b0;
        #1;
        chk("abort_dav", {7'b0, out_dav_}, 8'h01);
        chk("abort_data", out_data, 8'h00);
        chk("abort_rfd", {7'b0, in_rfd}, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
